// File: rtl/mult_seq_pkg.sv
// Shared constants for the shift-and-add multiplier sequencer: ALU select
// codes understood by the datapath ALU and the sequencer state encoding.
package mult_seq_pkg;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_PASS1 = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b100;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_mult_seq.sv
// Multi-cycle shift-and-add multiplier that borrows the shared datapath ALU in ADD mode.
// Optional MULT_EARLY_EXIT_EN ends RUN as soon as no multiplier bits remain.
module alu_mult_seq
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] alu_in0,
    output logic [WIDTH-1:0] alu_in1,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               done_q, done_d;
    logic               last_s;

    // Final RUN iteration detection
    always_comb begin
`ifdef MULT_EARLY_EXIT_EN
        last_s = (cnt_q == CNT_W'(WIDTH - 1)) || (mplier_q[WIDTH-1:1] == '0);
`else
        last_s = (cnt_q == CNT_W'(WIDTH - 1));
`endif
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                acc_d    = alu_result;
                mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_s) begin
                    result_d = alu_result;
                    state_d  = IDLE;
                    done_d   = 1'b1;
                end else begin
                    state_d  = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // The ALU adds the shifted multiplicand only when the current multiplier bit is set
    assign alu_in0 = acc_q;
    assign alu_in1 = mplier_q[0] ? mcand_q : '0;
    assign alu_sel = ALU_ADD;

    assign busy   = (state_q == RUN);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Directed bench for alu_mult_seq with a small combinational ALU and a result scoreboard.
// Build with MULT_EARLY_EXIT_EN defined to exercise the early-exit latencies.
module tb_alu_mult_seq;
    import mult_seq_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] op_a = 16'd0;
    logic [15:0] op_b = 16'd0;
    logic        busy, done;
    logic [15:0] result, alu_in0, alu_in1, alu_result;
    logic [2:0]  alu_sel;

    int n_cmp = 0;
    int n_mis = 0;
    logic [15:0] exp_q[$];

`ifdef MULT_EARLY_EXIT_EN
    localparam int IGNORE_AT = 2;
`else
    localparam int IGNORE_AT = 5;
`endif

    alu_mult_seq dut (
        .clock(clock), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .result(result),
        .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_sel(alu_sel), .alu_result(alu_result)
    );

    always #5 clock = ~clock;

    // Stand-in for the shared datapath ALU
    always_comb begin
        case (alu_sel)
            ALU_ADD:   alu_result = alu_in0 + alu_in1;
            ALU_SUB:   alu_result = alu_in0 - alu_in1;
            ALU_PASS1: alu_result = alu_in1;
            ALU_OR:    alu_result = alu_in0 | alu_in1;
            ALU_AND:   alu_result = alu_in0 & alu_in1;
            default:   alu_result = 16'd0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_run(input logic [15:0] b);
`ifdef MULT_EARLY_EXIT_EN
        int hi = 0;
        for (int i = 0; i < 16; i++) if (b[i]) hi = i;
        return hi + 1;
`else
        return 16;
`endif
    endfunction

    function automatic logic [15:0] prod(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] full;
        full = {16'd0, a} * {16'd0, b};
        return full[15:0];
    endfunction

    // The multiplier must keep the ALU in ADD mode throughout RUN
    always @(negedge clock) if (busy) check("alu_sel", {29'd0, alu_sel}, {29'd0, ALU_ADD});

    // Drive a start for one cycle and push the expected product
    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        @(negedge clock);
        start = 1'b1; op_a = a; op_b = b;
        exp_q.push_back(prod(a, b));
        @(posedge clock);
        #1 start = 1'b0; op_a = 16'($urandom); op_b = 16'($urandom);
    endtask

    // Count busy cycles until done, then compare against the scoreboard; returns on the done negedge
    task automatic wait_done(input string tag, input int run_exp);
        int run = 0;
        bit seen = 1'b0;
        logic [15:0] e;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            if (done) seen = 1'b1;
            else if (busy) run++;
        end
        check({tag, "_done"}, {31'd0, seen}, 32'd1);
        check({tag, "_run_cycles"}, run, run_exp);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        if (exp_q.size() == 0) check({tag, "_sb_empty"}, 32'd1, 32'd0);
        else begin
            e = exp_q.pop_front();
            check({tag, "_result"}, {16'd0, result}, {16'd0, e});
        end
    endtask

    // done must be a single-cycle pulse and result must hold
    task automatic after_done(input string tag, input logic [15:0] r);
        @(negedge clock);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_result_hold"}, {16'd0, result}, {16'd0, r});
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", {16'd0, result}, 32'd0);
        reset = 1'b0;

        launch(16'd3, 16'd5);
        wait_done("3x5", exp_run(16'd5));
        after_done("3x5", 16'd15);

        launch(16'd300, 16'd300);
        wait_done("300x300", exp_run(16'd300));
        after_done("300x300", 16'd24464);

        launch(16'hFFFF, 16'hFFFF);
        wait_done("ffffxffff", exp_run(16'hFFFF));
        after_done("ffffxffff", 16'd1);

        launch(16'd1234, 16'd0);
        wait_done("1234x0", exp_run(16'd0));
        after_done("1234x0", 16'd0);

        // Start pulsed during RUN must be ignored
        launch(16'd7, 16'd9);
        repeat (IGNORE_AT - 1) @(negedge clock);
        start = 1'b1; op_a = 16'd2; op_b = 16'd2;
        @(negedge clock);
        start = 1'b0;
        wait_done("7x9", exp_run(16'd9) - IGNORE_AT);
        check("7x9_val", {16'd0, result}, 32'd63);

        // Start during the done cycle is accepted
        start = 1'b1; op_a = 16'd4; op_b = 16'd4;
        exp_q.push_back(16'd16);
        @(posedge clock);
        #1 start = 1'b0;
        check("start_in_done_busy", {31'd0, busy}, 32'd1);
        wait_done("4x4", exp_run(16'd4));
        after_done("4x4", 16'd16);

        // Asynchronous reset in the middle of RUN
        @(negedge clock);
        start = 1'b1; op_a = 16'd10; op_b = 16'd10;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (2) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_result", {16'd0, result}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("arst_no_done", {31'd0, done}, 32'd0);
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("post_rst_idle", {30'd0, busy, done}, 32'd0);
        end

        launch(16'd6, 16'd7);
        wait_done("6x7", exp_run(16'd7));
        after_done("6x7", 16'd42);

        check("sb_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
